// File: rtl/euler_step_sequencer.sv
// Sequencer for the Euler update x[i] <= x[i] + h*f(x) over n_eq equations and num_steps steps.
// Optional build macro EULER_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle counter output cycle_cnt.
module euler_step_sequencer #(
  parameter int DATA_W = 32,
  parameter int N_MAX  = 8,
  parameter int IDX_W  = 3,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              rst_sync,
  input  logic              start,
  input  logic [IDX_W:0]    n_eq,
  input  logic [STEP_W-1:0] num_steps,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [IDX_W-1:0]  mem_addr,
  output logic              deriv_req,
  input  logic              deriv_ack,
  output logic              upd_start,
  input  logic              upd_done,
  output logic              busy,
  output logic              final_done,
  output logic [STEP_W-1:0] step_cnt
`ifdef EULER_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]       cycle_cnt
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_UPD  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [IDX_W:0]    N_MAX_EQ = (IDX_W + 1)'(N_MAX);
  localparam logic [IDX_W:0]    EQ_ONE   = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  // The address width must exactly cover the equation count.
  if (DATA_W < 1 || N_MAX != (1 << IDX_W)) begin : g_param_check
    $error("euler_step_sequencer: N_MAX must equal 2**IDX_W and DATA_W must be positive");
  end

  logic [2:0]        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [STEP_W-1:0] step_q;
  logic [IDX_W:0]    n_eq_q;
  logic [STEP_W-1:0] steps_q;

  logic [IDX_W:0] n_eq_clamped;
  logic           last_idx;
  logic           last_step;

  assign n_eq_clamped = (n_eq > N_MAX_EQ) ? N_MAX_EQ : n_eq;
  assign last_idx     = ({1'b0, idx_q} == (n_eq_q - EQ_ONE));
  assign last_step    = (step_q == (steps_q - STEP_ONE));

  // Control state and counters advance on the falling clock edge; either reset source aborts the run.
  always_ff @(negedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      n_eq_q  <= '0;
      steps_q <= '0;
    end else if (rst_sync) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      n_eq_q  <= '0;
      steps_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_eq_q  <= n_eq_clamped;
            steps_q <= num_steps;
            idx_q   <= '0;
            step_q  <= '0;
            state_q <= (n_eq == '0 || num_steps == '0) ? S_DONE : S_RD;
          end
        end
        S_RD:   state_q <= S_REQ;
        S_REQ:  if (deriv_ack) state_q <= S_UPD;
        S_UPD:  state_q <= S_WAIT;
        S_WAIT: if (upd_done) state_q <= S_WR;
        S_WR: begin
          if (!last_idx) begin
            idx_q   <= idx_q + IDX_ONE;
            state_q <= S_RD;
          end else if (last_step) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= '0;
            step_q  <= step_q + STEP_ONE;
            state_q <= S_RD;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_en  = (state_q == S_RD);
  assign deriv_req  = (state_q == S_REQ);
  assign upd_start  = (state_q == S_UPD);
  assign mem_wr_en  = (state_q == S_WR);
  assign final_done = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign mem_addr   = idx_q;
  assign step_cnt   = step_q;

`ifdef EULER_SEQ_CYCLE_CNT_EN
  // Counts busy cycles of the current run; it stops once DONE drops busy and saturates at all-ones.
  always_ff @(negedge clk or posedge rst_async) begin
    if (rst_async) begin
      cycle_cnt <= '0;
    end else if (rst_sync) begin
      cycle_cnt <= '0;
    end else if (state_q == S_IDLE && start) begin
      cycle_cnt <= '0;
    end else if (busy && cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/euler_step_sequencer.md
Name: euler_step_sequencer

Overview:
Controller that sequences the Euler integration datapath x[i] <= x[i] + h*f(x) over n_eq state variables for num_steps time steps. It consumes the one-cycle start pulse produced by the Euler start FSM and drives the state-memory read/write strobes, the derivative-unit handshake and the update-unit start/done handshake. It returns final_done to the start FSM when the last step is written back.

Parameters:
DATA_W, 32, datapath word width (pass-through only; no arithmetic on data in this block)
N_MAX, 8, maximum number of equations; must be a power of two
IDX_W, 3, log2(N_MAX); width of the equation index / memory address
STEP_W, 16, width of the step counter and num_steps

Ports:
clk  in  1  clock; all state updates on falling edge
rst_async  in  1  reset, asynchronous, active-high
rst_sync  in  1  synchronous reset, active-high, sampled on falling edge; same effect as rst_async
start  in  1  start pulse; sampled only in IDLE
n_eq  in  IDX_W+1  equation count, 0..N_MAX; latched at start
num_steps  in  STEP_W  number of Euler steps; latched at start
mem_rd_en  out  1  state-memory read strobe
mem_wr_en  out  1  state-memory write strobe
mem_addr  out  IDX_W  equation index being processed
deriv_req  out  1  derivative request to f(x) unit
deriv_ack  in  1  derivative result valid
upd_start  out  1  one-cycle pulse that starts the x + h*f multiply-add
upd_done  in  1  update result valid
busy  out  1  high from the first cycle after an accepted start until final_done
final_done  out  1  one-cycle completion pulse to the start FSM
step_cnt  out  STEP_W  index of the step in progress

Behaviour:
- Reset (either source): state=IDLE. All outputs 0. Index and step counters 0. Latched n_eq and num_steps cleared. Reset mid-operation aborts with no final_done; any in-flight deriv_req or upd handshake is dropped.
- All outputs are registered/Moore, decoded from state.
- IDLE: busy=0.
  - start=1 with latched n_eq!=0 and num_steps!=0 -> RD; idx=0, step=0.
  - start=1 with n_eq==0 or num_steps==0 -> DONE; no memory or handshake activity.
  - n_eq>N_MAX is clamped to N_MAX.
- RD: mem_rd_en=1 for exactly one cycle; mem_addr=idx -> REQ.
- REQ: deriv_req=1, held until deriv_ack=1 is sampled; then -> UPD. deriv_ack in any other state is ignored.
- UPD: upd_start=1 for one cycle -> WAIT.
- WAIT: hold until upd_done=1 -> WR. upd_done in any other state is ignored.
- WR: mem_wr_en=1 for one cycle; mem_addr=idx.
  - If idx!=n_eq-1: idx++, -> RD.
  - Else if step==num_steps-1: -> DONE.
  - Else: idx=0, step++, -> RD. Step increments only after the last equation of a step is written.
- DONE: final_done=1 for one cycle, busy=0 -> IDLE. step_cnt holds its final value until the next accepted start.
- start while busy is ignored; no queueing.
- Minimum cost per equation: 5 cycles (RD, REQ with immediate ack, UPD, WAIT with immediate done, WR).
- Counter arithmetic is unsigned and modulo-free. The step compare uses num_steps-1, so num_steps=2^STEP_W-1 is the maximum supported value.

Optional Feature:
EULER_SEQ_CYCLE_CNT_EN
- Defined: adds output cycle_cnt[31:0]. It is cleared on accepted start, increments every cycle while busy=1, and freezes on final_done (saturates at 0xFFFFFFFF). Reset value is 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then n_eq=2, num_steps=3, start pulse, deriv_ack and upd_done returned the cycle after request -> 6 mem_wr_en pulses at addresses 0,1,0,1,0,1; step_cnt 0,1,2; final_done one cycle after the 6th write; 30 cycles start-to-DONE.
- n_eq=1, num_steps=1, deriv_ack delayed 4 cycles -> deriv_req held high exactly 5 cycles; single write to address 0; final_done once.
- start with num_steps=0 (and separately n_eq=0) -> no mem_rd_en or mem_wr_en; final_done asserted 1 cycle after start; busy never 1.
- Second start pulse and spurious deriv_ack/upd_done issued mid-run (n_eq=4, num_steps=2) -> ignored; exactly 8 writes; single final_done.
- rst_async asserted while in WAIT -> all outputs 0 immediately with no final_done; a new start afterwards runs normally from idx=0, step=0.
- With EULER_SEQ_CYCLE_CNT_EN, n_eq=2, num_steps=3, immediate handshakes -> cycle_cnt=30 at final_done, held afterwards, cleared on next start.
